// File: rtl/digit_step_ctrl.sv
// digit_step_ctrl: button-driven step sequencer for the per-digit up/down counters.
// Takes debounced buttons and arbitrates up > down > left > right, one action at
// a time. It issues one-hot step strobes under a wrap-around cursor, and holding
// up or down produces auto-repeat.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// IDLE         | waiting for a rising edge on a direction button
// HOLD_DELAY   | up/down owner held; counting toward the first auto-repeat step
// HOLD_REPEAT  | up/down owner still held; stepping every REPEAT_PERIOD cycles
// WAIT_RELEASE | left/right owner held; cursor already moved, waiting for release
module digit_step_ctrl #(
  parameter int DIGITS        = 4,
  parameter int CW            = 2,
  parameter int TW            = 24,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_fast,
  output logic [DIGITS-1:0] digit_step,
  output logic              cnt_updown,
  output logic              cnt_inc,
  output logic [CW-1:0]     cursor,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HOLD_DELAY   = 2'd1,
    HOLD_REPEAT  = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // Owner codes double as the bit index into the packed button vector.
  localparam logic [1:0] OWN_UP    = 2'd0;
  localparam logic [1:0] OWN_DOWN  = 2'd1;
  localparam logic [1:0] OWN_LEFT  = 2'd2;
  localparam logic [1:0] OWN_RIGHT = 2'd3;

  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CURSOR_LAST = CW'(DIGITS - 1);

  state_t            state;
  logic [1:0]        owner;
  logic [TW-1:0]     timer;
  logic [3:0]        btn;
  logic [3:0]        btn_q;
  logic [3:0]        rise;
  logic              owner_lvl;
  logic              repeat_hit;
  logic [DIGITS-1:0] step_vec;
  logic [CW-1:0]     cursor_inc;
  logic [CW-1:0]     cursor_dec;

  assign btn        = {btn_right, btn_left, btn_down, btn_up};
  assign rise       = btn & ~btn_q;
  assign owner_lvl  = btn[owner];
  assign step_vec   = DIGITS'(1) << cursor;
  assign cursor_inc = (cursor == CURSOR_LAST) ? '0 : cursor + 1'b1;
  assign cursor_dec = (cursor == '0) ? CURSOR_LAST : cursor - 1'b1;
  // The terminal count depends on whether the first repeat is still pending.
  assign repeat_hit = (state == HOLD_DELAY) ? (timer == DELAY_LAST)
                                            : (timer == PERIOD_LAST);

  // Button history for rising-edge detection; preloaded high so buttons held through reset are ignored.
  always_ff @(posedge clk) begin
    if (reset) btn_q <= '1;
    else       btn_q <= btn;
  end

  // Sequencer FSM with registered strobe, qualifiers, cursor and busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_UP;
      timer      <= '0;
      cursor     <= '0;
      digit_step <= '0;
      cnt_updown <= 1'b0;
      cnt_inc    <= 1'b0;
      busy       <= 1'b0;
    end else if (clr) begin
      // Qualifiers keep their values so the counters see no spurious change.
      state      <= IDLE;
      timer      <= '0;
      cursor     <= '0;
      digit_step <= '0;
      busy       <= 1'b0;
    end else begin
      digit_step <= '0;
      case (state)
        IDLE: begin
          if (rise[OWN_UP] || rise[OWN_DOWN]) begin
            owner      <= rise[OWN_UP] ? OWN_UP : OWN_DOWN;
            cnt_updown <= ~rise[OWN_UP];
            cnt_inc    <= btn_fast;
            digit_step <= step_vec;
            timer      <= '0;
            state      <= HOLD_DELAY;
            busy       <= 1'b1;
          end else if (rise[OWN_LEFT]) begin
            owner  <= OWN_LEFT;
            cursor <= cursor_inc;
            state  <= WAIT_RELEASE;
            busy   <= 1'b1;
          end else if (rise[OWN_RIGHT]) begin
            owner  <= OWN_RIGHT;
            cursor <= cursor_dec;
            state  <= WAIT_RELEASE;
            busy   <= 1'b1;
          end
        end
        HOLD_DELAY, HOLD_REPEAT: begin
          // Release wins over a coincident terminal count: no step on the release edge.
          if (!owner_lvl) begin
            state <= IDLE;
            timer <= '0;
            busy  <= 1'b0;
          end else if (repeat_hit) begin
            digit_step <= step_vec;
            cnt_inc    <= btn_fast;
            timer      <= '0;
            state      <= HOLD_REPEAT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (!owner_lvl) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_step_ctrl.sv
// Testbench for digit_step_ctrl: directed table and sequences plus randomized
// stimulus checked every cycle against an age-based behavioural model.
module tb_digit_step_ctrl;

  localparam int RD = 8;
  localparam int RP = 3;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       btn_up, btn_down, btn_left, btn_right, btn_fast;
  logic [3:0] digit_step;
  logic       cnt_updown;
  logic       cnt_inc;
  logic [1:0] cursor;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  digit_step_ctrl #(
    .DIGITS(4), .CW(2), .TW(8), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_fast(btn_fast),
    .digit_step(digit_step), .cnt_updown(cnt_updown), .cnt_inc(cnt_inc),
    .cursor(cursor), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: an action has an age in cycles since its start edge;
  // steps occur at age 0, age RD, then every RP cycles while the owner stays high.
  logic [3:0] m_prev;
  bit         m_active;
  bit         m_hold;
  logic [1:0] m_owner;
  int         m_age;
  logic [3:0] m_step;
  logic [1:0] m_cursor;
  logic       m_updown;
  logic       m_inc;

  always @(posedge clk) begin : model
    logic [3:0] b;
    logic [3:0] r;
    b = {btn_right, btn_left, btn_down, btn_up};
    r = b & ~m_prev;
    m_step = 4'b0000;
    if (reset) begin
      m_prev   = 4'b1111;
      m_active = 0;
      m_cursor = 2'd0;
      m_updown = 1'b0;
      m_inc    = 1'b0;
    end else begin
      m_prev = b;
      if (clr) begin
        m_active = 0;
        m_cursor = 2'd0;
      end else if (!m_active) begin
        if (r[0] || r[1]) begin
          m_active = 1;
          m_hold   = 1;
          m_owner  = r[0] ? 2'd0 : 2'd1;
          m_age    = 0;
          m_updown = !r[0];
          m_inc    = btn_fast;
          m_step   = 4'b0001 << m_cursor;
        end else if (r[2]) begin
          m_active = 1;
          m_hold   = 0;
          m_owner  = 2'd2;
          m_cursor = 2'((int'(m_cursor) + 1) % 4);
        end else if (r[3]) begin
          m_active = 1;
          m_hold   = 0;
          m_owner  = 2'd3;
          m_cursor = 2'((int'(m_cursor) + 3) % 4);
        end
      end else begin
        m_age = m_age + 1;
        if (!b[m_owner]) begin
          m_active = 0;
        end else if (m_hold && (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0))) begin
          m_step = 4'b0001 << m_cursor;
          m_inc  = btn_fast;
        end
      end
    end
  end

  // Compare every registered output with the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if ({digit_step, cursor, busy, cnt_updown, cnt_inc} !==
          {m_step, m_cursor, m_active, m_updown, m_inc}) begin
        n_fail++;
        $display("FAIL model @%0t: got step=%b cur=%0d busy=%b ud=%b inc=%b, expected step=%b cur=%0d busy=%b ud=%b inc=%b",
                 $time, digit_step, cursor, busy, cnt_updown, cnt_inc,
                 m_step, m_cursor, m_active, m_updown, m_inc);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic       up, down, left, right;
    logic [3:0] step;
    logic [1:0] cur;
    logic       bsy;
    logic       updown;
  } vec_t;

  vec_t vecs[14];

  task automatic setv(input int i, input logic u, input logic d, input logic l, input logic r,
                      input logic [3:0] s, input logic [1:0] c, input logic b, input logic ud);
    vecs[i].up = u; vecs[i].down = d; vecs[i].left = l; vecs[i].right = r;
    vecs[i].step = s; vecs[i].cur = c; vecs[i].bsy = b; vecs[i].updown = ud;
  endtask

  initial begin
    int cnt;
    // Cursor wrap, simultaneous press, then an up press; starts idle at cursor 0 with cnt_updown=1.
    setv(0,  0,0,1,0, 4'b0000, 2'd1, 1, 1);
    setv(1,  0,0,0,0, 4'b0000, 2'd1, 0, 1);
    setv(2,  0,0,1,0, 4'b0000, 2'd2, 1, 1);
    setv(3,  0,0,0,0, 4'b0000, 2'd2, 0, 1);
    setv(4,  0,0,1,0, 4'b0000, 2'd3, 1, 1);
    setv(5,  0,0,0,0, 4'b0000, 2'd3, 0, 1);
    setv(6,  0,0,1,0, 4'b0000, 2'd0, 1, 1);
    setv(7,  0,0,0,0, 4'b0000, 2'd0, 0, 1);
    setv(8,  0,0,0,1, 4'b0000, 2'd3, 1, 1);
    setv(9,  0,0,0,0, 4'b0000, 2'd3, 0, 1);
    setv(10, 0,1,1,1, 4'b1000, 2'd3, 1, 1);
    setv(11, 0,0,0,0, 4'b0000, 2'd3, 0, 1);
    setv(12, 1,0,0,0, 4'b1000, 2'd3, 1, 0);
    setv(13, 0,0,0,0, 4'b0000, 2'd3, 0, 0);

    reset = 1; clr = 0;
    btn_up = 1; btn_down = 0; btn_left = 0; btn_right = 0; btn_fast = 0;
    cyc(1);
    chk_en = 1;
    cyc(2);
    chk("reset_state", 32'({digit_step, cursor, busy, cnt_updown, cnt_inc}), 32'd0);

    // Reset with btn_up held: no action until released and pressed again.
    reset = 0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (digit_step != 4'b0000 || busy) cnt++;
    end
    chk("held_through_reset", 32'(cnt), 32'd0);
    btn_up = 0; cyc(1);
    btn_up = 1; cyc(1);
    chk("repress_step", 32'(digit_step), 32'b0001);
    chk("repress_updown", 32'(cnt_updown), 32'd0);
    chk("repress_busy", 32'(busy), 32'd1);
    btn_up = 0; cyc(1);
    chk("quick_release_busy", 32'(busy), 32'd0);

    // Auto-repeat: down with fast, fast dropped before edge t+5.
    btn_down = 1; btn_fast = 1;
    for (int k = 1; k <= 21; k++) begin
      cyc(1);
      if (k <= 20) begin
        if (k == 1 || k == 9 || k == 12 || k == 15 || k == 18) begin
          chk($sformatf("repeat_step_k%0d", k), 32'(digit_step), 32'b0001);
          chk($sformatf("repeat_updown_k%0d", k), 32'(cnt_updown), 32'd1);
        end else begin
          chk($sformatf("repeat_nostep_k%0d", k), 32'(digit_step), 32'd0);
        end
        chk($sformatf("repeat_inc_k%0d", k), 32'(cnt_inc), (k <= 8) ? 32'd1 : 32'd0);
      end else begin
        chk("repeat_release_busy", 32'(busy), 32'd0);
      end
      if (k == 4) btn_fast = 0;
      if (k == 20) btn_down = 0;
    end

    // Table-driven cursor and arbitration vectors.
    for (int i = 0; i < 14; i++) begin
      btn_up = vecs[i].up; btn_down = vecs[i].down;
      btn_left = vecs[i].left; btn_right = vecs[i].right;
      cyc(1);
      chk($sformatf("vec%0d_step", i), 32'(digit_step), 32'(vecs[i].step));
      chk($sformatf("vec%0d_cursor", i), 32'(cursor), 32'(vecs[i].cur));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("vec%0d_updown", i), 32'(cnt_updown), 32'(vecs[i].updown));
    end

    // Release race: low sample lands on timer = REPEAT_DELAY-1.
    btn_up = 1; cyc(1);
    chk("race_first_step", 32'(digit_step), 32'b1000);
    cnt = 0;
    for (int k = 2; k <= 8; k++) begin
      cyc(1);
      if (digit_step != 4'b0000 || !busy) cnt++;
    end
    chk("race_hold_quiet", 32'(cnt), 32'd0);
    btn_up = 0; cyc(1);
    chk("race_no_step", 32'(digit_step), 32'd0);
    chk("race_busy_fall", 32'(busy), 32'd0);

    // Soft clear during HOLD_REPEAT at cursor 2.
    btn_right = 1; cyc(1);
    chk("clr_setup_cursor", 32'(cursor), 32'd2);
    btn_right = 0; cyc(1);
    btn_up = 1; cyc(1);
    chk("clr_first_step", 32'(digit_step), 32'b0100);
    cnt = 0;
    for (int k = 2; k <= 10; k++) begin
      cyc(1);
      if (digit_step != 4'b0000) cnt++;
    end
    chk("clr_pre_steps", 32'(cnt), 32'd1);
    chk("clr_pre_busy", 32'(busy), 32'd1);
    clr = 1; cyc(1); clr = 0;
    chk("clr_cursor", 32'(cursor), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_updown_held", 32'(cnt_updown), 32'd0);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      cyc(1);
      if (digit_step != 4'b0000 || busy) cnt++;
    end
    chk("clr_no_restart", 32'(cnt), 32'd0);
    btn_up = 0; cyc(2);

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) btn_up    = ~btn_up;
      if ($urandom_range(15) == 0) btn_down  = ~btn_down;
      if ($urandom_range(7)  == 0) btn_left  = ~btn_left;
      if ($urandom_range(7)  == 0) btn_right = ~btn_right;
      btn_fast = 1'($urandom_range(1));
      clr      = ($urandom_range(63) == 0);
      reset    = ($urandom_range(499) == 0);
      cyc(1);
    end
    reset = 0; clr = 0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
